// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream loader that writes 32-bit words into instruction memory
module imem_loader #(
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_hold,
    output logic        load_ok,
    output logic        load_err,
    output logic [15:0] word_count
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LEN_LO = 3'd1;
    localparam logic [2:0] LEN_HI = 3'd2;
    localparam logic [2:0] DATA   = 3'd3;
    localparam logic [2:0] CSUM   = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;
    localparam logic [2:0] ERROR  = 3'd6;
    localparam logic [16:0] MAX_N = 17'd1 << ADDR_W;

    logic [2:0]  state_q, state_d;
    logic [7:0]  len_lo_q, len_lo_d;
    logic [15:0] n_q, n_d;
    logic [7:0]  csum_q, csum_d;
    logic [1:0]  lane_q, lane_d;
    logic [23:0] buf_q, buf_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        hold_q, hold_d;
    logic        ok_q, ok_d;
    logic        err_q, err_d;
    logic [15:0] wc_q, wc_d;
    logic        xfer;
    logic [15:0] len_w;

    assign in_ready   = !rst;
    assign xfer       = in_valid && in_ready;
    assign len_w      = {in_data, len_lo_q};
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign core_hold  = hold_q;
    assign load_ok    = ok_q;
    assign load_err   = err_q;
    assign word_count = wc_q;

    always_comb begin
        state_d  = state_q;
        len_lo_d = len_lo_q;
        n_d      = n_q;
        csum_d   = csum_q;
        lane_d   = lane_q;
        buf_d    = buf_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        hold_d   = hold_q;
        ok_d     = ok_q;
        err_d    = err_q;
        wc_d     = wc_q;
        if (xfer) begin
            case (state_q)
                IDLE, DONE, ERROR: begin
                    if (in_data == SYNC_BYTE) begin
                        state_d = LEN_LO;
                        hold_d  = 1'b1;
                        ok_d    = 1'b0;
                        err_d   = 1'b0;
                        wc_d    = 16'd0;
                        csum_d  = 8'd0;
                        lane_d  = 2'd0;
                    end
                end
                LEN_LO: begin
                    len_lo_d = in_data;
                    state_d  = LEN_HI;
                end
                LEN_HI: begin
                    n_d = len_w;
                    if (len_w == 16'd0 || {1'b0, len_w} > MAX_N) begin
                        state_d = ERROR;
                        hold_d  = 1'b0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = DATA;
                    end
                end
                DATA: begin
                    csum_d = csum_q ^ in_data;
                    lane_d = lane_q + 2'd1;
                    buf_d  = {in_data, buf_q[23:8]};
                    // little-endian: the lane-3 byte lands on top of the three buffered bytes
                    if (lane_q == 2'd3) begin
                        we_d    = 1'b1;
                        wdata_d = {in_data, buf_q};
                        addr_d  = BASE_ADDR + {14'd0, wc_q, 2'b00};
                        wc_d    = wc_q + 16'd1;
                        state_d = (wc_q + 16'd1 == n_q) ? CSUM : DATA;
                    end
                end
                CSUM: begin
                    state_d = (in_data == csum_q) ? DONE : ERROR;
                    hold_d  = 1'b0;
                    ok_d    = in_data == csum_q;
                    err_d   = in_data != csum_q;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            len_lo_q <= 8'd0;
            n_q      <= 16'd0;
            csum_q   <= 8'd0;
            lane_q   <= 2'd0;
            buf_q    <= 24'd0;
            we_q     <= 1'b0;
            addr_q   <= BASE_ADDR;
            wdata_q  <= 32'd0;
            hold_q   <= 1'b0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
            wc_q     <= 16'd0;
        end else begin
            state_q  <= state_d;
            len_lo_q <= len_lo_d;
            n_q      <= n_d;
            csum_q   <= csum_d;
            lane_q   <= lane_d;
            buf_q    <= buf_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            hold_q   <= hold_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
            wc_q     <= wc_d;
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed frames with a write scoreboard checked by an independent monitor
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_hold;
    logic        load_ok;
    logic        load_err;
    logic [15:0] word_count;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        e;
    logic [7:0] s[$];
    int         vectors = 0;
    int         miscompares = 0;

    imem_loader dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .core_hold (core_hold),
        .load_ok   (load_ok),
        .load_err  (load_err),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", imem_addr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", imem_addr, e.a);
                chk("wr_data", imem_wdata, e.d);
            end
        end
    end

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back('{a: a, d: d});
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
    endtask

    // idle cycles drive the sync value with valid low to prove it is ignored
    task automatic gap(input int n);
        in_valid = 1'b0;
        in_data  = 8'hA5;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run(input bit toggle, input bit hold_chk);
        foreach (s[i]) begin
            send(s[i]);
            if (hold_chk && i < s.size() - 1) chk("core_hold_busy", {31'd0, core_hold}, 32'd1);
            if (toggle) gap(1);
        end
        in_valid = 1'b0;
    endtask

    task automatic status(input logic ok, input logic err, input logic [15:0] wc);
        chk("load_ok", {31'd0, load_ok}, {31'd0, ok});
        chk("load_err", {31'd0, load_err}, {31'd0, err});
        chk("core_hold_idle", {31'd0, core_hold}, 32'd0);
        chk("word_count", {16'd0, word_count}, {16'd0, wc});
    endtask

    task automatic drained();
        gap(3);
        chk("writes_drained", exp_q.size(), 32'd0);
    endtask

    task automatic reset_vals();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_we", {31'd0, imem_we}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_hold", {31'd0, core_hold}, 32'd0);
        chk("rst_ok", {31'd0, load_ok}, 32'd0);
        chk("rst_err", {31'd0, load_err}, 32'd0);
        chk("rst_wc", {16'd0, word_count}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        reset_vals();
        rst = 1'b0;
        #1;
        chk("ready_after_rst", {31'd0, in_ready}, 32'd1);

        // good two-word frame; 13^93^10 = 90
        push(32'h0, 32'h0000_0013);
        push(32'h4, 32'h0010_0093);
        s = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        run(1'b0, 1'b1);
        status(1'b1, 1'b0, 16'd2);
        drained();
        chk("addr_hold", imem_addr, 32'h4);
        chk("wdata_hold", imem_wdata, 32'h0010_0093);

        // same frame, bad checksum
        push(32'h0, 32'h0000_0013);
        push(32'h4, 32'h0010_0093);
        s = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h81};
        run(1'b0, 1'b1);
        status(1'b0, 1'b1, 16'd2);
        drained();

        // bad lengths
        s = '{8'hA5, 8'h00, 8'h00};
        run(1'b0, 1'b0);
        status(1'b0, 1'b1, 16'd0);
        drained();
        s = '{8'hA5, 8'h01, 8'h01};
        run(1'b0, 1'b0);
        status(1'b0, 1'b1, 16'd0);
        drained();

        // noise before sync; 78^56^34^12 = 08
        s = '{8'h00, 8'hFF, 8'h3C};
        run(1'b0, 1'b0);
        status(1'b0, 1'b1, 16'd0);
        push(32'h0, 32'h1234_5678);
        s = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
        run(1'b0, 1'b1);
        status(1'b1, 1'b0, 16'd1);
        drained();

        // reset after six data bytes
        push(32'h0, 32'h0000_0013);
        s = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00};
        run(1'b0, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        reset_vals();
        rst = 1'b0;
        drained();
        push(32'h0, 32'h0000_0013);
        push(32'h4, 32'h0010_0093);
        s = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        run(1'b0, 1'b1);
        status(1'b1, 1'b0, 16'd2);
        drained();

        // toggled valid, sync value as payload; A5^11^22^33^01^02^03^04 = A1
        push(32'h0, 32'h3322_11A5);
        push(32'h4, 32'h0403_0201);
        s = '{8'hA5, 8'h02, 8'h00, 8'hA5, 8'h11, 8'h22, 8'h33, 8'h01, 8'h02, 8'h03, 8'h04, 8'hA1};
        run(1'b1, 1'b1);
        status(1'b1, 1'b0, 16'd2);
        drained();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
